// File: rtl/im_loader.sv
// Byte-stream program loader: frames UART bytes into 17-bit words and drives the
// instruction-memory write port, holding the CPU in reset while an image loads.
module im_loader #(
  parameter int          ADDR_W    = 11,
  parameter int          DATA_W    = 17,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_B0, S_B1, S_B2, S_CHK
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_b0;
  logic [7:0]        r_b1;
  logic [7:0]        r_chk;
  logic [TO_W-1:0]   r_idle;

  logic w_timeout;
  logic w_sync;
  logic w_write;
  logic w_err;
  logic w_done;

  // The idle counter only runs inside a frame; any received byte restarts it.
  assign w_timeout = (r_state != S_IDLE) && !rx_vld && (r_idle == TO_W'(TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sync      = 1'b0;
    w_write     = 1'b0;
    w_err       = 1'b0;
    w_done      = 1'b0;
    if (w_timeout) begin
      w_err       = 1'b1;
      w_state_nxt = S_IDLE;
    end else if (rx_vld) begin
      case (r_state)
        S_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            w_sync      = 1'b1;
            w_state_nxt = S_CNT_LO;
          end
        end
        S_CNT_LO: w_state_nxt = S_CNT_HI;
        S_CNT_HI: begin
          if (rx_data[7:ADDR_W-8] != '0) begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_B0;
          end
        end
        S_B0: w_state_nxt = S_B1;
        S_B1: w_state_nxt = S_B2;
        S_B2: begin
          if (rx_data[7:1] != '0) begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_write     = 1'b1;
            w_state_nxt = (r_addr == r_cnt) ? S_CHK : S_B0;
          end
        end
        S_CHK: begin
          if (rx_data == r_chk) w_done = 1'b1;
          else                  w_err  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_b0      <= '0;
      r_b1      <= '0;
      r_chk     <= '0;
      r_idle    <= '0;
      im_we     <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      im_we     <= w_write;
      load_done <= w_done;
      r_idle    <= (r_state == S_IDLE || rx_vld) ? '0 : r_idle + 1'b1;

      if (w_sync) begin
        load_err <= 1'b0;
        cpu_hold <= 1'b1;
        r_addr   <= '0;
        r_chk    <= '0;
      end
      if (w_err) begin
        load_err <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (w_done) cpu_hold <= 1'b0;

      if (rx_vld && !w_timeout) begin
        case (r_state)
          S_CNT_LO: r_cnt[7:0]        <= rx_data;
          S_CNT_HI: r_cnt[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
          S_B0: begin
            r_b0  <= rx_data;
            r_chk <= r_chk ^ rx_data;
          end
          S_B1: begin
            r_b1  <= rx_data;
            r_chk <= r_chk ^ rx_data;
          end
          S_B2:    r_chk <= r_chk ^ rx_data;
          default: ;
        endcase
      end

      // Write-port registers only move on a write, so address/data hold until the next one.
      if (w_write) begin
        im_waddr <= r_addr;
        im_wdata <= {rx_data[0], r_b1, r_b0};
        r_addr   <= r_addr + 1'b1;
      end
    end
  end

endmodule
